register: RTL and testbench

//   Architectural integer register file (x0..x31) for the 5-stage RV32I core.
//   - Serves the decode stage: two combinational read ports, with rs1/rs2 address and read-enable from id.
//   - Accepts one write per cycle from the write-back stage.
//   - Same-cycle write-to-read bypass, so decode sees write-back data without an extra hazard stall.

---
 rtl/register.sv | 87 ++++++++
 tb/tb_register.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/register.sv
// Architectural integer register file (x0..x31): two combinational read ports with
// same-cycle write-to-read bypass, one write port. Optional trace port under REGFILE_TRACE_EN.
module register #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data,
    output logic [31:0]       trace_count
`endif
);

    // No valid/ready: every write with we=1 and waddr!=0 is accepted on the next
    // rising edge; reads are pure combinational lookups with no backpressure.
    logic [DATA_W-1:0] regs [REG_NUM];
    logic              commit;

    assign commit = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[waddr] <= wdata;
        end
    end

    // Priority: reset, read disabled, x0, bypass from write-back, stored value.
    always_comb begin
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

`ifdef REGFILE_TRACE_EN
    // Address/data hold their last committed values when no write commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
            trace_count <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_addr  <= waddr;
                trace_data  <= wdata;
                trace_count <= trace_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for the register file: the driver pushes expected read data per
// cycle, a negedge monitor pops and compares. Trace checks run when REGFILE_TRACE_EN is defined.
module tb_register;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
`ifdef REGFILE_TRACE_EN
    logic              trace_valid;
    logic [ADDR_W-1:0] trace_addr;
    logic [DATA_W-1:0] trace_data;
    logic [31:0]       trace_count;
`endif

    register #(.REG_NUM(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
`ifdef REGFILE_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_count (trace_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [2*DATA_W-1:0] exp_q[$];
    string               name_q[$];
    logic [69:0]         tr_q[$];
    logic                rd_sample = 1'b0;
    logic                tr_sample = 1'b0;
    int                  checks = 0;
    int                  errors = 0;

    // driver: apply one cycle of inputs just after the rising edge and queue
    // the expected combinational read data for that cycle
    task automatic apply(input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic e1, input logic [ADDR_W-1:0] a1,
                         input logic e2, input logic [ADDR_W-1:0] a2,
                         input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] x2,
                         input string nm);
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        exp_q.push_back({x1, x2});
        name_q.push_back(nm);
        rd_sample = 1'b1;
        tr_sample = 1'b0;
    endtask

    task automatic push_tr(input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [31:0] c);
        tr_q.push_back({v, a, d, c});
        tr_sample = 1'b1;
    endtask

    // monitor
    always @(negedge clk) begin
        logic [2*DATA_W-1:0] e;
        string               nm;
        if (rd_sample) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: read sample with empty expected queue");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({rdata1, rdata2} !== e) begin
                    errors++;
                    $display("FAIL %s: rdata1=%h rdata2=%h expected %h %h",
                             nm, rdata1, rdata2, e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
`ifdef REGFILE_TRACE_EN
        if (tr_sample) begin
            logic [69:0] t;
            checks++;
            if (tr_q.size() == 0) begin
                errors++;
                $display("FAIL trace_underflow: trace sample with empty queue");
            end else begin
                t = tr_q.pop_front();
                if ({trace_valid, trace_addr, trace_data, trace_count} !== t) begin
                    errors++;
                    $display("FAIL trace: v=%b a=%0d d=%h c=%h expected v=%b a=%0d d=%h c=%h",
                             trace_valid, trace_addr, trace_data, trace_count,
                             t[69], t[68:64], t[63:32], t[31:0]);
                end
            end
        end
`endif
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

        // preload, then reset with a colliding write; reads are zero during reset
        apply(0, 1, 5'd1, 32'h0000_0011, 1, 5'd1, 0, 5'd0, 32'h11, 32'h0, "bypass_x1");
        apply(0, 1, 5'd9, 32'h0000_0099, 1, 5'd1, 1, 5'd9, 32'h11, 32'h99, "read_x1_bypass_x9");
        apply(1, 1, 5'd3, 32'h0000_00AA, 1, 5'd1, 1, 5'd9, 32'h0, 32'h0, "read_during_rst");
        for (int i = 1; i < 32; i++) begin
            apply(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i), 32'h0, 32'h0, "post_rst_zero");
        end

        // write then read next cycle
        apply(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "write_x5");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, "read_x5");

        // same-cycle bypass on both ports, then stored value
        apply(0, 1, 5'd7, 32'h1234_5678, 1, 5'd7, 1, 5'd7, 32'h1234_5678, 32'h1234_5678, "bypass_both");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7, 32'h1234_5678, 32'h1234_5678, "stored_both");

        // x0 write ignored; disabled read port returns 0 even for a live register
        apply(0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, "x0_write_cycle");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd5, 32'h0, 32'h0, "x0_next_cycle");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, 32'hDEAD_BEEF, 32'h0, "re2_off");

        // reset collision then write in the first cycle after reset
        apply(1, 1, 5'd3, 32'h0000_00AA, 1, 5'd3, 1, 5'd5, 32'h0, 32'h0, "rst_collision");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd5, 32'h0, 32'h0, "x3_after_rst");
        apply(0, 1, 5'd3, 32'h0000_00BB, 1, 5'd3, 1, 5'd7, 32'hBB, 32'h0, "first_write_after_rst");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3, 32'hBB, 32'hBB, "x3_committed");

        // back-to-back writes; bypass only on matching address
        apply(0, 1, 5'd10, 32'h1, 1, 5'd3, 1, 5'd10, 32'hBB, 32'h1, "b2b_first");
        apply(0, 1, 5'd10, 32'h2, 1, 5'd10, 1, 5'd10, 32'h2, 32'h2, "b2b_second");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd10, 1, 5'd3, 32'h2, 32'hBB, "b2b_last_wins");
        apply(0, 1, 5'd31, 32'hCAFE_F00D, 1, 5'd31, 1, 5'd10, 32'hCAFE_F00D, 32'h2, "x31_bypass");
        apply(0, 0, 5'd0, 32'h0, 1, 5'd31, 0, 5'd31, 32'hCAFE_F00D, 32'h0, "x31_stored");

`ifdef REGFILE_TRACE_EN
        apply(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_rst");
        apply(0, 1, 5'd2, 32'h22, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_w2");
        push_tr(1'b0, 5'd0, 32'h0, 32'd0);
        apply(0, 1, 5'd0, 32'h55, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_w0");
        push_tr(1'b1, 5'd2, 32'h22, 32'd1);
        apply(0, 1, 5'd4, 32'h44, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_w4");
        push_tr(1'b0, 5'd2, 32'h22, 32'd1);
        apply(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_idle");
        push_tr(1'b1, 5'd4, 32'h44, 32'd2);
        apply(0, 1, 5'd6, 32'h66, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_wrap_write");
        force dut.trace_count = 32'hFFFF_FFFF;
        #1;
        release dut.trace_count;
        apply(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "trace_wrap_check");
        push_tr(1'b1, 5'd6, 32'h66, 32'd0);
`endif

        @(posedge clk);
        #1;
        rd_sample = 1'b0;
        tr_sample = 1'b0;
        @(negedge clk);
        checks++;
        if ((exp_q.size() != 0) || (tr_q.size() != 0)) begin
            errors++;
            $display("FAIL drain: %0d read and %0d trace expectations left, expected 0 and 0",
                     exp_q.size(), tr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
